lsu_mem_ctrl: RTL and testbench

- Parametrised load/store controller that replaces the pass-through MEM stage.
- Accepts one scalar load/store request at a time: byte, half, word, or (DATA_W=64 only) double, with sign or zero extension.
- Generates RAM byte-lane bit masks, shifts write data into lanes, and aligns and extends read data.
- Splits accesses that cross a RAM word boundary into two RAM beats; supports RAM read latency of 1 or more cycles.

---
 rtl/lsu_mem_if.sv | 39 +++
 rtl/lsu_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if.sv
// Request/response and RAM port bundle for the load/store controller.
// The controller side uses the slave modport; the requester/RAM environment uses master.
interface lsu_mem_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RAM_ADDR_W = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_W-1:0]     req_addr_i;
    logic [DATA_W-1:0]     req_wdata_i;
    logic                  resp_valid_o;
    logic [DATA_W-1:0]     resp_rdata_o;
    logic                  resp_err_o;
    logic                  ram_r_ena_o;
    logic [RAM_ADDR_W-1:0] ram_r_addr_o;
    logic [DATA_W-1:0]     ram_r_data_i;
    logic                  ram_w_ena_o;
    logic [RAM_ADDR_W-1:0] ram_w_addr_o;
    logic [DATA_W-1:0]     ram_w_data_o;
    logic [DATA_W-1:0]     ram_w_mask_o;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
               ram_r_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o, ram_w_mask_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
               ram_r_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o, ram_w_mask_o
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Scalar load/store controller: byte-lane masking, write-lane shifting, read alignment/extension,
// and two-beat splitting of accesses that straddle a RAM word boundary.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RAM_ADDR_W  = 32,
    parameter int unsigned RAM_LAT     = 1,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    lsu_mem_if.slave  bus
);
    localparam int unsigned B    = DATA_W / 8;
    localparam int unsigned OW   = $clog2(B);
    localparam int unsigned CW   = $clog2(RAM_LAT + 1);
    localparam int unsigned BM_W = 2 * B;
    localparam int unsigned IW   = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;
    state_t state, state_nxt;

    logic                  we_q, uns_q, split_q, err_q;
    logic [1:0]            size_q;
    logic [OW-1:0]         off_q;
    logic [RAM_ADDR_W-1:0] widx_q;
    logic [DATA_W-1:0]     wdata_q, rd0_q, rd1_q;
    logic [CW-1:0]         lat_cnt;

    logic          hs, req_err, req_split, lat_done;
    logic [OW-1:0] req_off;
    logic [3:0]    req_n, n_q;

    assign hs        = bus.req_valid_i && (state == IDLE);
    assign req_off   = bus.req_addr_i[OW-1:0];
    assign req_n     = 4'd1 << bus.req_size_i;
    assign req_split = (32'(req_off) + 32'(req_n)) > B;
    assign lat_done  = (32'(lat_cnt) == RAM_LAT - 1);
    assign n_q       = 4'd1 << size_q;

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size_i == 2'd3 && DATA_W == 32)
            req_err = 1'b1;
        if (!MISALIGN_EN && ((bus.req_addr_i & ADDR_W'(req_n - 4'd1)) != '0))
            req_err = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = req_err ? RESP : ISSUE0;
            ISSUE0:  state_nxt = we_q ? (split_q ? ISSUE1 : RESP) : WAIT0;
            WAIT0:   if (lat_done) state_nxt = split_q ? ISSUE1 : RESP;
            ISSUE1:  state_nxt = we_q ? RESP : WAIT1;
            WAIT1:   if (lat_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            lat_cnt <= '0;
        end else begin
            if (hs) begin
                we_q    <= bus.req_we_i;
                uns_q   <= bus.req_unsigned_i;
                split_q <= req_split;
                err_q   <= req_err;
                size_q  <= bus.req_size_i;
                off_q   <= req_off;
                widx_q  <= RAM_ADDR_W'(bus.req_addr_i >> OW);
                wdata_q <= bus.req_wdata_i;
            end
            if (state == ISSUE0 || state == ISSUE1)
                lat_cnt <= '0;
            else if (state == WAIT0 || state == WAIT1)
                lat_cnt <= lat_cnt + CW'(1);
            if (state == WAIT0 && lat_done) rd0_q <= bus.ram_r_data_i;
            if (state == WAIT1 && lat_done) rd1_q <= bus.ram_r_data_i;
        end
    end

    // Both beats are viewed as one double-width window: low half is beat 0, high half beat 1.
    logic [BM_W-1:0]     bmask;
    logic [2*DATA_W-1:0] lane_mask, wide_wdata, wide_rdata;
    logic [DATA_W-1:0]   ld_data;
    logic [IW-1:0]       sidx;
    logic                sign;

    always_comb begin
        bmask      = ((BM_W'(1) << n_q) - BM_W'(1)) << off_q;
        lane_mask  = '0;
        for (int unsigned i = 0; i < BM_W; i++)
            lane_mask[8*i +: 8] = {8{bmask[i]}};
        wide_wdata = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
        wide_rdata = {rd1_q, rd0_q} >> {off_q, 3'b000};
        sidx       = IW'({n_q, 3'b000}) - IW'(1);
        sign       = !uns_q && wide_rdata[sidx];
        ld_data    = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
            ld_data[i] = (i < 32'({n_q, 3'b000})) ? wide_rdata[i] : sign;
    end

    always_comb begin
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        bus.resp_rdata_o = '0;
        bus.resp_err_o   = 1'b0;
        bus.ram_r_ena_o  = 1'b0;
        bus.ram_r_addr_o = '0;
        bus.ram_w_ena_o  = 1'b0;
        bus.ram_w_addr_o = '0;
        bus.ram_w_data_o = '0;
        bus.ram_w_mask_o = '0;
        case (state)
            IDLE: bus.req_ready_o = 1'b1;
            ISSUE0: begin
                if (we_q) begin
                    bus.ram_w_ena_o  = 1'b1;
                    bus.ram_w_addr_o = widx_q;
                    bus.ram_w_data_o = wide_wdata[DATA_W-1:0];
                    bus.ram_w_mask_o = lane_mask[DATA_W-1:0];
                end else begin
                    bus.ram_r_ena_o  = 1'b1;
                    bus.ram_r_addr_o = widx_q;
                end
            end
            ISSUE1: begin
                if (we_q) begin
                    bus.ram_w_ena_o  = 1'b1;
                    bus.ram_w_addr_o = widx_q + RAM_ADDR_W'(1);
                    bus.ram_w_data_o = wide_wdata[2*DATA_W-1:DATA_W];
                    bus.ram_w_mask_o = lane_mask[2*DATA_W-1:DATA_W];
                end else begin
                    bus.ram_r_ena_o  = 1'b1;
                    bus.ram_r_addr_o = widx_q + RAM_ADDR_W'(1);
                end
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_err_o   = err_q;
                bus.resp_rdata_o = (we_q || err_q) ? '0 : ld_data;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: three instances cover the default configuration,
// strict alignment, and a 3-cycle RAM with an 8-bit word index (wrap and mid-access reset).
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    lsu_mem_if #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(32)) a_if ();
    lsu_mem_if #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(32)) b_if ();
    lsu_mem_if #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(8))  c_if ();

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(32), .RAM_LAT(1), .MISALIGN_EN(1'b1))
        u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(32), .RAM_LAT(1), .MISALIGN_EN(1'b0))
        u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .RAM_ADDR_W(8), .RAM_LAT(3), .MISALIGN_EN(1'b1))
        u_c (.clk(clk), .rst(rst2), .bus(c_if.slave));

    logic        va, vb, vc, t_we, t_uns;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_wdata;

    assign a_if.req_valid_i = va;
    assign b_if.req_valid_i = vb;
    assign c_if.req_valid_i = vc;
    assign a_if.req_we_i = t_we;     assign b_if.req_we_i = t_we;     assign c_if.req_we_i = t_we;
    assign a_if.req_size_i = t_size; assign b_if.req_size_i = t_size; assign c_if.req_size_i = t_size;
    assign a_if.req_unsigned_i = t_uns;  assign b_if.req_unsigned_i = t_uns;  assign c_if.req_unsigned_i = t_uns;
    assign a_if.req_addr_i = t_addr;     assign b_if.req_addr_i = t_addr;     assign c_if.req_addr_i = t_addr;
    assign a_if.req_wdata_i = t_wdata;   assign b_if.req_wdata_i = t_wdata;   assign c_if.req_wdata_i = t_wdata;

    // Shared RAM model: instance a reads/writes with latency 1, instance c reads with latency 3.
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    logic [7:0]  a_s0, c_s0, c_s1, c_s2;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (a_if.ram_w_ena_o)
            mem[a_if.ram_w_addr_o[7:0]] <= (mem[a_if.ram_w_addr_o[7:0]] & ~a_if.ram_w_mask_o)
                                         | (a_if.ram_w_data_o & a_if.ram_w_mask_o);
        a_s0 <= a_if.ram_r_addr_o[7:0];
        c_s0 <= c_if.ram_r_addr_o;
        c_s1 <= c_s0;
        c_s2 <= c_s1;
    end

    assign a_if.ram_r_data_i = mem[a_s0];
    assign b_if.ram_r_data_i = '0;
    assign c_if.ram_r_data_i = mem[c_s2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Returns at the negedge of cycle 1 (one posedge after the accepting edge).
    task automatic req(input int which, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
        va = (which == 0); vb = (which == 1); vc = (which == 2);
        @(negedge clk);
        va = 1'b0; vb = 1'b0; vc = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; rst2 = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        t_we = 1'b0; t_size = '0; t_uns = 1'b0; t_addr = '0; t_wdata = '0;
        step(2);
        check("rst_ready_a", a_if.req_ready_o, 1'b1);
        check("rst_resp_a", a_if.resp_valid_o, 1'b0);
        check("rst_ready_c", c_if.req_ready_o, 1'b1);
        check("rst_rena_c", c_if.ram_r_ena_o, 1'b0);
        rst = 1'b0; rst2 = 1'b0;

        poke(8'h40, 32'h80123456);
        poke(8'h3F, 32'hAABBCCDD);
        poke(8'h41, 32'h00000000);
        poke(8'hFF, 32'h55667788);
        poke(8'h00, 32'h99AABBCC);

        // Load byte signed / unsigned at 0x103
        req(0, 1'b0, 2'd0, 1'b0, 32'h103, '0);
        check("t1_rena", a_if.ram_r_ena_o, 1'b1);
        check("t1_raddr", a_if.ram_r_addr_o, 32'h40);
        check("t1_busy", a_if.req_ready_o, 1'b0);
        step(1); check("t1_early", a_if.resp_valid_o, 1'b0);
        step(1); check("t1_valid", a_if.resp_valid_o, 1'b1);
        check("t1_rdata", a_if.resp_rdata_o, 32'hFFFFFF80);
        check("t1_err", a_if.resp_err_o, 1'b0);
        step(1); check("t1_ready_back", a_if.req_ready_o, 1'b1);
        check("t1_pulse", a_if.resp_valid_o, 1'b0);
        check("t1_rdata_cleared", a_if.resp_rdata_o, 32'h0);
        req(0, 1'b0, 2'd0, 1'b1, 32'h103, '0);
        step(2); check("t1u_valid", a_if.resp_valid_o, 1'b1);
        check("t1u_rdata", a_if.resp_rdata_o, 32'h00000080);

        // Split word load at 0x0FE
        poke(8'h40, 32'h11223344);
        req(0, 1'b0, 2'd2, 1'b0, 32'h0FE, '0);
        check("t3_raddr0", a_if.ram_r_addr_o, 32'h3F);
        check("t3_rena0", a_if.ram_r_ena_o, 1'b1);
        step(1); check("t3_wait_rena", a_if.ram_r_ena_o, 1'b0);
        step(1); check("t3_raddr1", a_if.ram_r_addr_o, 32'h40);
        check("t3_rena1", a_if.ram_r_ena_o, 1'b1);
        step(1); check("t3_early", a_if.resp_valid_o, 1'b0);
        step(1); check("t3_valid", a_if.resp_valid_o, 1'b1);
        check("t3_rdata", a_if.resp_rdata_o, 32'h3344AABB);

        // Store half at 0x102, then read it back signed
        req(0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF);
        check("t2_wena", a_if.ram_w_ena_o, 1'b1);
        check("t2_waddr", a_if.ram_w_addr_o, 32'h40);
        check("t2_wdata", a_if.ram_w_data_o, 32'hBEEF0000);
        check("t2_wmask", a_if.ram_w_mask_o, 32'hFFFF0000);
        check("t2_rena", a_if.ram_r_ena_o, 1'b0);
        step(1); check("t2_valid", a_if.resp_valid_o, 1'b1);
        check("t2_err", a_if.resp_err_o, 1'b0);
        check("t2_rdata", a_if.resp_rdata_o, 32'h0);
        req(0, 1'b0, 2'd1, 1'b0, 32'h102, '0);
        step(2); check("t2r_rdata", a_if.resp_rdata_o, 32'hFFFFBEEF);

        // Split word store at 0x103, then split load back
        req(0, 1'b1, 2'd2, 1'b0, 32'h103, 32'hDEADBEEF);
        check("t4_waddr0", a_if.ram_w_addr_o, 32'h40);
        check("t4_wdata0", a_if.ram_w_data_o, 32'hEF000000);
        check("t4_wmask0", a_if.ram_w_mask_o, 32'hFF000000);
        step(1); check("t4_wena1", a_if.ram_w_ena_o, 1'b1);
        check("t4_waddr1", a_if.ram_w_addr_o, 32'h41);
        check("t4_wdata1", a_if.ram_w_data_o, 32'h00DEADBE);
        check("t4_wmask1", a_if.ram_w_mask_o, 32'h00FFFFFF);
        check("t4_early", a_if.resp_valid_o, 1'b0);
        step(1); check("t4_valid", a_if.resp_valid_o, 1'b1);
        req(0, 1'b0, 2'd2, 1'b0, 32'h103, '0);
        step(4); check("t4r_valid", a_if.resp_valid_o, 1'b1);
        check("t4r_rdata", a_if.resp_rdata_o, 32'hDEADBEEF);

        // Double on a 32-bit datapath is illegal even with misalignment allowed
        req(0, 1'b0, 2'd3, 1'b0, 32'h100, '0);
        check("t5a_valid", a_if.resp_valid_o, 1'b1);
        check("t5a_err", a_if.resp_err_o, 1'b1);
        check("t5a_rena", a_if.ram_r_ena_o, 1'b0);

        // Strict alignment instance
        req(1, 1'b0, 2'd1, 1'b0, 32'h101, '0);
        check("t5_valid", b_if.resp_valid_o, 1'b1);
        check("t5_err", b_if.resp_err_o, 1'b1);
        check("t5_rena", b_if.ram_r_ena_o, 1'b0);
        check("t5_wena", b_if.ram_w_ena_o, 1'b0);
        step(1); check("t5_ready_back", b_if.req_ready_o, 1'b1);
        check("t5_err_pulse", b_if.resp_err_o, 1'b0);
        req(1, 1'b0, 2'd3, 1'b0, 32'h100, '0);
        check("t5d_err", b_if.resp_err_o, 1'b1);
        req(1, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF);
        check("t5s_wena", b_if.ram_w_ena_o, 1'b1);
        check("t5s_wmask", b_if.ram_w_mask_o, 32'hFFFF0000);
        step(1); check("t5s_valid", b_if.resp_valid_o, 1'b1);
        check("t5s_err", b_if.resp_err_o, 1'b0);

        // Latency 3, split load wrapping word 0xFF -> 0x00
        req(2, 1'b0, 2'd2, 1'b0, 32'h3FE, '0);
        check("t6_raddr0", c_if.ram_r_addr_o, 8'hFF);
        check("t6_rena0", c_if.ram_r_ena_o, 1'b1);
        step(4); check("t6_rena1", c_if.ram_r_ena_o, 1'b1);
        check("t6_raddr_wrap", c_if.ram_r_addr_o, 8'h00);
        step(3); check("t6_early", c_if.resp_valid_o, 1'b0);
        step(1); check("t6_valid", c_if.resp_valid_o, 1'b1);
        check("t6_rdata", c_if.resp_rdata_o, 32'hBBCC5566);

        // Reset during WAIT1 aborts the access
        req(2, 1'b0, 2'd2, 1'b0, 32'h3FE, '0);
        step(6);
        #1 rst2 = 1'b1;
        #1;
        check("t6r_ready_async", c_if.req_ready_o, 1'b1);
        check("t6r_resp", c_if.resp_valid_o, 1'b0);
        check("t6r_rena", c_if.ram_r_ena_o, 1'b0);
        step(2);
        rst2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (c_if.resp_valid_o) seen = 1'b1;
        end
        check("t6r_no_resp", seen, 1'b0);
        check("t6r_ready_after", c_if.req_ready_o, 1'b1);
        req(2, 1'b0, 2'd0, 1'b0, 32'h3FC, '0);
        step(3); check("t6r_early", c_if.resp_valid_o, 1'b0);
        step(1); check("t6r_valid", c_if.resp_valid_o, 1'b1);
        check("t6r_rdata", c_if.resp_rdata_o, 32'hFFFFFF88);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
